// File: rtl/vga_pkg.sv
// Shared VGA timing constants, controller state encoding and default colours
// for the pixel generator and its sub-blocks.
package vga_pkg;

    localparam int H_DISP  = 640;
    localparam int V_DISP  = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [11:0] DEF_BG_COLOR  = 12'h00F;
    localparam logic [11:0] DEF_BOX_COLOR = 12'hFF0;

    // True when lo <= p < lo+len, widened to 11 bits so the upper bound never wraps.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo,
                                     input logic [10:0] len);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + len));
    endfunction

endpackage

// File: rtl/pixel_gen_if.sv
// Video stream between the sync stage (master) and the pixel generator (slave):
// pixel coordinates and enables in, colour and frame marker out.
interface pixel_gen_if;

    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] rgb;
    logic        frame_tick;

    modport master (
        output p_tick, video_on, pixel_x, pixel_y,
        input  rgb, frame_tick
    );

    modport slave (
        input  p_tick, video_on, pixel_x, pixel_y,
        output rgb, frame_tick
    );

endinterface

// File: rtl/bounce_axis.sv
// One axis of box motion: position and direction registers with clamp-and-reflect
// at 0 and LIMIT, advanced by STEP on each enabled cycle.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = H_DISP - 32,
    parameter int STEP  = 2,
    parameter int INIT  = 304
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en_i,
    output logic [9:0] pos_o
);

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] LIMIT_W = 11'(LIMIT);
    localparam logic [9:0]  INIT_P  = 10'(INIT);

    logic [9:0]  pos_q;
    logic [9:0]  pos_d;
    logic        dir_q;
    logic        dir_d;
    logic [10:0] fwd_s;

    assign fwd_s = {1'b0, pos_q} + STEP_W;

    // Next position: clamp onto the wall and reverse when the step would reach it.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_en_i) begin
            if (dir_q) begin
                if (fwd_s >= LIMIT_W) begin
                    pos_d = LIMIT_W[9:0];
                    dir_d = 1'b0;
                end else begin
                    pos_d = fwd_s[9:0];
                    dir_d = 1'b1;
                end
            end else begin
                if ({1'b0, pos_q} <= STEP_W) begin
                    pos_d = 10'd0;
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_q - STEP_W[9:0];
                    dir_d = 1'b0;
                end
            end
        end else begin
            pos_d = pos_q;
            dir_d = dir_q;
        end
    end

    // Position and direction state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q <= INIT_P;
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/pixel_gen.sv
// Bouncing-square pixel generator behind the VGA sync stage: registered RGB,
// once-per-frame motion and a start/pause controller.
module pixel_gen
    import vga_pkg::*;
#(
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          X_INIT    = 304,
    parameter int          Y_INIT    = 224,
    parameter logic [11:0] BG_COLOR  = DEF_BG_COLOR,
    parameter logic [11:0] BOX_COLOR = DEF_BOX_COLOR
) (
    input  logic        clk,
    input  logic        reset,
    pixel_gen_if.slave  vid,
    input  logic        start,
    input  logic        pause,
    output logic        busy
);

    state_t      state_q;
    logic        busy_q;
    logic [11:0] rgb_q;
    logic [9:0]  box_x_s;
    logic [9:0]  box_y_s;
    logic        frame_tick_s;
    logic        move_s;
    logic        hit_s;

    // First pixel of vertical blanking; the position update lands here, out of sight.
    assign frame_tick_s = vid.p_tick & (vid.pixel_x == 10'd0) & (vid.pixel_y == 10'(V_DISP));
    assign move_s       = frame_tick_s & (state_q == ST_RUN);

    bounce_axis #(.LIMIT(H_DISP - BOX_SIZE), .STEP(STEP), .INIT(X_INIT)) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .step_en_i (move_s),
        .pos_o     (box_x_s)
    );

    bounce_axis #(.LIMIT(V_DISP - BOX_SIZE), .STEP(STEP), .INIT(Y_INIT)) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .step_en_i (move_s),
        .pos_o     (box_y_s)
    );

    assign hit_s = in_span(vid.pixel_x, box_x_s, 11'(BOX_SIZE))
                 & in_span(vid.pixel_y, box_y_s, 11'(BOX_SIZE));

    // Run/pause controller; busy is registered alongside the state it decodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= pause ? ST_PAUSE : ST_RUN;
                    busy_q  <= 1'b1;
                end
                ST_PAUSE: begin
                    state_q <= pause ? ST_PAUSE : ST_RUN;
                    busy_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel colour, loaded once per pixel and held for both clocks of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= 12'h000;
        end else if (vid.p_tick) begin
            if (!vid.video_on) begin
                rgb_q <= 12'h000;
            end else if (hit_s) begin
                rgb_q <= BOX_COLOR;
            end else begin
                rgb_q <= BG_COLOR;
            end
        end else begin
            rgb_q <= rgb_q;
        end
    end

    assign vid.rgb        = rgb_q;
    assign vid.frame_tick = frame_tick_s;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pixel_gen.sv
// Self-checking bench for pixel_gen: the bench plays the sync stage with short
// synthetic frames and compares against a behavioural model every clock.
module tb_pixel_gen;
    import vga_pkg::*;

    localparam int          STEP = 2;
    localparam int          BOX  = 32;
    localparam int          XL   = H_DISP - BOX;
    localparam int          YL   = V_DISP - BOX;
    localparam logic [11:0] BG   = 12'h00F;
    localparam logic [11:0] FG   = 12'hFF0;
    localparam logic [11:0] BLK  = 12'h000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic busy;

    pixel_gen_if vif ();

    pixel_gen dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vif.slave),
        .start (start),
        .pause (pause),
        .busy  (busy)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ft_cnt = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_x, m_y, m_mode;
    bit          m_dx, m_dy;
    logic [11:0] m_rgb;
    logic        m_busy;

    function automatic int step_pos(input int p, input bit d, input int lim);
        if (d) return (p + STEP >= lim) ? lim : p + STEP;
        else   return (p <= STEP) ? 0 : p - STEP;
    endfunction

    function automatic bit step_dir(input int p, input bit d, input int lim);
        if (d) return !(p + STEP >= lim);
        else   return (p <= STEP);
    endfunction

    // mode: 0 idle, 1 running, 2 paused
    function automatic int next_mode(input int md, input logic s, input logic p);
        case (md)
            0:       return s ? 1 : 0;
            1:       return p ? 2 : 1;
            2:       return p ? 2 : 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] colour(input int x, input int y, input logic vo,
                                           input int bx, input int by);
        if (!vo) return BLK;
        if (x >= bx && x < bx + BOX && y >= by && y < by + BOX) return FG;
        return BG;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_x <= 304; m_y <= 224; m_dx <= 1'b1; m_dy <= 1'b1;
            m_mode <= 0; m_rgb <= BLK; m_busy <= 1'b0;
        end else begin
            if (vif.p_tick)
                m_rgb <= colour(int'(vif.pixel_x), int'(vif.pixel_y), vif.video_on, m_x, m_y);
            if (vif.p_tick && vif.pixel_x == 10'd0 && vif.pixel_y == 10'd480 && m_mode == 1) begin
                m_x  <= step_pos(m_x, m_dx, XL);
                m_dx <= step_dir(m_x, m_dx, XL);
                m_y  <= step_pos(m_y, m_dy, YL);
                m_dy <= step_dir(m_y, m_dy, YL);
            end
            m_mode <= next_mode(m_mode, start, pause);
            m_busy <= (next_mode(m_mode, start, pause) != 0);
        end
    end

    // Per-clock comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("rgb", int'(vif.rgb), int'(m_rgb));
        check("busy", int'(busy), int'(m_busy));
        check("frame_tick", int'(vif.frame_tick),
              int'(vif.p_tick && vif.pixel_x == 10'd0 && vif.pixel_y == 10'd480));
        if (vif.frame_tick === 1'b1) ft_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic drive_pix(input int x, input int y);
        @(posedge clk); #2;
        vif.p_tick   = 1'b1;
        vif.pixel_x  = 10'(x);
        vif.pixel_y  = 10'(y);
        vif.video_on = (x >= 0 && x < H_DISP && y >= 0 && y < V_DISP);
        @(posedge clk); #2;
        vif.p_tick   = 1'b0;
    endtask

    task automatic check_pix(input int x, input int y, input logic [11:0] exp, input string nm);
        drive_pix(x, y);
        @(negedge clk);
        check(nm, int'(vif.rgb), int'(exp));
    endtask

    task automatic do_frame();
        drive_pix(m_x - 1, m_y);
        drive_pix(m_x, m_y);
        drive_pix(m_x + BOX - 1, m_y + BOX - 1);
        drive_pix(m_x + BOX, m_y + BOX - 1);
        drive_pix(m_x + BOX - 1, m_y + BOX);
        drive_pix(H_TOTAL - 1, V_TOTAL - 1);
        drive_pix(1, V_DISP);
        drive_pix(0, V_DISP - 1);
        drive_pix(0, V_DISP);
    endtask

    initial begin
        vif.p_tick = 1'b0; vif.video_on = 1'b0; vif.pixel_x = 10'd0; vif.pixel_y = 10'd0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rgb", int'(vif.rgb), int'(BLK));
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #2 reset = 1'b1;

        // reset asserted in the middle of a line
        check_pix(320, 240, FG, "pre_reset_box");
        @(posedge clk); #2 reset = 1'b0;
        drive_pix(321, 240);
        @(negedge clk);
        check("midline_reset_rgb", int'(vif.rgb), int'(BLK));
        @(posedge clk); #2 reset = 1'b1;

        // idle frame
        check_pix(320, 240, FG, "idle_center");
        check_pix(0, 0, BG, "idle_origin");
        check_pix(700, 100, BLK, "idle_hblank");
        check_pix(100, 500, BLK, "idle_vblank");
        do_frame();
        check_pix(304, 224, FG, "idle_still_tl");
        check_pix(303, 224, BG, "idle_still_left");

        // start, then three frames of motion
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        ft_cnt = 0;
        repeat (3) do_frame();
        check("ft_count_3", ft_cnt, 3);
        check_pix(310, 230, FG, "m3_tl");
        check_pix(309, 230, BG, "m3_left");
        check_pix(310, 229, BG, "m3_above");
        check_pix(341, 261, FG, "m3_br");
        check_pix(342, 230, BG, "m3_right");

        // right clamp after 152 frames in total; y already reflected off the bottom
        repeat (149) do_frame();
        check_pix(608, 368, FG, "rclamp_tl");
        check_pix(607, 368, BG, "rclamp_left");
        check_pix(639, 399, FG, "rclamp_br");
        check_pix(608, 400, BG, "rclamp_below");
        do_frame();
        check_pix(606, 366, FG, "rback_tl");
        check_pix(638, 366, BG, "rback_right");

        // left clamp at frame 456; y bounced off the top at frame 336
        repeat (303) do_frame();
        check_pix(0, 240, FG, "lclamp_tl");
        check_pix(32, 240, BG, "lclamp_right");
        check_pix(0, 239, BG, "lclamp_above");
        do_frame();
        check_pix(2, 242, FG, "lback_tl");
        check_pix(1, 242, BG, "lback_left");

        // pause across two frames
        @(posedge clk); #2 pause = 1'b1;
        repeat (2) do_frame();
        @(negedge clk);
        check("busy_paused", int'(busy), 1);
        check_pix(2, 242, FG, "pause_tl");
        check_pix(1, 242, BG, "pause_left");
        @(posedge clk); #2 pause = 1'b0;
        do_frame();
        check_pix(4, 244, FG, "resume_tl");
        check_pix(3, 244, BG, "resume_left");

        // pixel latency at the box edge and at the end of the visible line
        check_pix(3, 244, BG, "lat_pre");
        @(posedge clk); #2;
        vif.p_tick = 1'b1; vif.pixel_x = 10'd4; vif.pixel_y = 10'd244; vif.video_on = 1'b1;
        @(negedge clk);
        check("lat_not_early", int'(vif.rgb), int'(BG));
        @(posedge clk); #2 vif.p_tick = 1'b0;
        @(negedge clk);
        check("lat_edge", int'(vif.rgb), int'(FG));
        @(posedge clk);
        @(negedge clk);
        check("lat_hold", int'(vif.rgb), int'(FG));
        check_pix(639, 244, BG, "last_visible");
        check_pix(640, 244, BLK, "first_hblank");

        // reset mid-frame, then start and pause together from idle
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("midframe_rst_rgb", int'(vif.rgb), int'(BLK));
        check("midframe_rst_busy", int'(busy), 0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 start = 1'b1; pause = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check("busy_start_pause", int'(busy), 1);
        do_frame();
        check_pix(304, 224, FG, "sp_still_tl");
        check_pix(303, 224, BG, "sp_still_left");
        @(posedge clk); #2 pause = 1'b0;
        do_frame();
        check_pix(306, 226, FG, "sp_moved_tl");
        check_pix(305, 226, BG, "sp_moved_left");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
